// File: rtl/cpu_fetch_unit.sv
// Decoupled instruction-fetch front end: credit-limited in-order requests, a response FIFO
// holding {pc, instruction}, and redirect handling that flushes and drops stale responses.
module cpu_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [ADDR_W-1:0] redirect_aligned;
  logic [CntW:0]     in_use;
  logic              credit_ok;
  logic              fifo_empty;
  logic              req_fire;
  logic              rsp_take;
  logic              push;
  logic              pop;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Stale requests keep their credit until their response returns.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok = in_use < (CntW + 1)'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error; it is ignored.
  assign rsp_take = imem_rsp_valid && !rst && (outstanding_q != '0);
  assign push     = rsp_take && !redirect_valid && (drop_cnt_q == '0);

  assign fifo_empty = (count_q == '0);
  assign inst_valid = !fifo_empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  assign inst    = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign inst_pc = fifo_empty ? '0 : pc_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d    = redirect_aligned;
      rsp_pc_d      = redirect_aligned;
      outstanding_d = outstanding_q - CntW'(rsp_take);
      drop_cnt_d    = outstanding_q - CntW'(rsp_take);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_take);
      if (rsp_take && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != '0));
`endif

endmodule
